// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM encoding,
// register-index constants, control-field widths and the load-use check.
package pipe_ctrl_pkg;

  // Memory-wait FSM encoding
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  // Register file indexing; x0 is hard-wired to zero and never a hazard
  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0    = '0;

  // Control-field widths carried by the pipeline registers
  localparam int EX_CTRL_W = 4;
  localparam int M_CTRL_W  = 2;
  localparam int WB_CTRL_W = 2;

  // A load in EX whose destination is read by the instruction in ID
  function automatic logic load_use_hazard(
    input logic                 ex_mem_read,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] id_rs1,
    input logic [REG_IDX_W-1:0] id_rs2,
    input logic                 id_uses_rs2
  );
    return ex_mem_read && (ex_rd != REG_X0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Clear has priority; otherwise count enabled cycles until all-ones
  always_ff @(posedge clk) begin
    if (srst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles,
// branch squash, data-memory freeze with timeout watchdog, and
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_uses_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [0:0]      state_reg, state_next;
  logic [TO_W-1:0] wait_reg, wait_next;
  logic            err_reg;
  logic            hazard;
  logic            timeout;
  logic            memstall;

  assign hazard  = load_use_hazard(EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_uses_rs2_i);
  assign timeout = (state_reg == MEM_WAIT) && (wait_reg == TO_LIMIT) && !mem_ack_i;
  assign memstall = ((state_reg == MEM_WAIT) && !mem_ack_i && !timeout) ||
                    ((state_reg == RUN) && mem_req_i && !mem_ack_i);

  // Prioritised pipeline controls: reset, memory freeze, load-use, branch
  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    pipe_stall_o  = 1'b0;
    if (rst_i) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
      pipe_stall_o  = 1'b1;
    end else if (memstall) begin
      // Whole pipe frozen; hazard/branch are re-evaluated once it moves
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      pipe_stall_o  = 1'b1;
    end else if (hazard) begin
      // Hold IF/ID, inject one bubble while the load drains from ID/EX
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o  = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM and its wait counter
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_next = MEM_WAIT;
          wait_next  = TO_W'(1);
        end
      end
      default: begin
        if (mem_ack_i || timeout) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_reg != '1) begin
          wait_next  = wait_reg + TO_W'(1);
        end
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_o = err_reg;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .srst  (rst_i),
    .en    (!PC_write_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .srst  (rst_i),
    .en    (IFID_flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table,
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 8;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_stall}
  localparam logic [4:0] O_RST   = 5'b00011;
  localparam logic [4:0] O_MEM   = 5'b00001;
  localparam logic [4:0] O_HAZ   = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11100;
  localparam logic [4:0] O_NORM  = 5'b11000;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             uses_rs2, mem_read, br, req, ack;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_rs1_i       (rs1),
    .ID_rs2_i       (rs2),
    .ID_uses_rs2_i  (uses_rs2),
    .EX_MemRead_i   (mem_read),
    .EX_rd_i        (rd),
    .branch_taken_i (br),
    .mem_req_i      (req),
    .mem_ack_i      (ack),
    .PC_write_o     (pc_write),
    .IFID_write_o   (ifid_write),
    .IFID_flush_o   (ifid_flush),
    .IDEX_bubble_o  (idex_bubble),
    .pipe_stall_o   (pipe_stall),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       mem_read;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       ack;
    logic [4:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: stall cycles already spent on the outstanding access
  int m_waited = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  bit m_err    = 1'b0;

  function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                              input logic u, input logic mr, input logic [4:0] d,
                              input logic b, input logic q, input logic k, input logic [4:0] e);
    vec_t v;
    v.rst = r; v.rs1 = a1; v.rs2 = a2; v.uses_rs2 = u; v.mem_read = mr;
    v.rd = d; v.br = b; v.req = q; v.ack = k; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] model_outs(input vec_t v);
    bit haz, busy;
    if (v.rst) return O_RST;
    haz = v.mem_read && (v.rd != 0) && ((v.rd == v.rs1) || (v.uses_rs2 && (v.rd == v.rs2)));
    if (m_waited > 0) busy = !v.ack && (m_waited < MEM_TIMEOUT);
    else              busy = v.req && !v.ack;
    if (busy) return O_MEM;
    if (haz)  return O_HAZ;
    if (v.br) return O_BR;
    return O_NORM;
  endfunction

  task automatic model_edge(input vec_t v, input logic [4:0] o);
    if (v.rst) begin
      m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!o[4] && m_stall < CNT_MAX) m_stall++;
      if (o[2] && m_flush < CNT_MAX)  m_flush++;
      if (m_waited > 0) begin
        if (v.ack) m_waited = 0;
        else if (m_waited == MEM_TIMEOUT) begin m_err = 1'b1; m_waited = 0; end
        else m_waited++;
      end else if (v.req && !v.ack) begin
        m_waited = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, compare, advance the model
  task automatic step(input vec_t v, input string name, input bit use_tbl);
    logic [4:0] mo, dut_o;
    rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; uses_rs2 = v.uses_rs2; mem_read = v.mem_read;
    rd = v.rd; br = v.br; req = v.req; ack = v.ack;
    @(negedge clk);
    mo    = model_outs(v);
    dut_o = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall};
    check({name, "/outs"}, 64'(dut_o), 64'(mo));
    check({name, "/regs"}, {47'd0, err, stall_cnt, flush_cnt}, {47'd0, m_err, CNT_W'(m_stall), CNT_W'(m_flush)});
    if (use_tbl) check({name, "/table"}, 64'(dut_o), 64'(v.exp));
    $display("cyc %s rst=%0b req=%0b ack=%0b haz_in=%0b br=%0b -> outs=%05b stall_cnt=%0d flush_cnt=%0d err=%0b",
             name, v.rst, v.req, v.ack, v.mem_read, v.br, dut_o, stall_cnt, flush_cnt, err);
    @(posedge clk);
    model_edge(v, mo);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST), "reset", 1'b1);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; uses_rs2 = 0; mem_read = 0; br = 0; req = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: forced outputs, cleared registers
    do_reset(2);
    check("reset_err", 64'(err), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);

    // Single-cycle directed vectors from RUN with no outstanding access
    tbl[0] = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, O_HAZ);   // load-use on rs1
    tbl[1] = mk(0, 5, 0, 0, 0, 5, 0, 0, 0, O_NORM);  // not a load
    tbl[2] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM);  // x0 never hazards
    tbl[3] = mk(0, 1, 7, 0, 1, 7, 0, 0, 0, O_NORM);  // rs2 not used
    tbl[4] = mk(0, 1, 7, 1, 1, 7, 0, 0, 0, O_HAZ);   // rs2 used
    tbl[5] = mk(0, 1, 2, 1, 0, 3, 1, 0, 0, O_BR);    // taken branch squash
    tbl[6] = mk(0, 4, 2, 1, 1, 4, 1, 0, 0, O_HAZ);   // branch depends on load
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM);  // single-cycle access
    tbl[8] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR);    // single-cycle access + branch
    for (int i = 0; i < 9; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i), 1'b1);
      if (i == 0) check("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);
      if (i == 5) check("branch_flush_cnt", 64'(flush_cnt), 64'd1);
    end
    check("tbl_stall_cnt", 64'(stall_cnt), 64'd3);
    check("tbl_flush_cnt", 64'(flush_cnt), 64'd2);

    // Memory wait, ack on the 4th cycle, hazard+branch present during wait
    do_reset(1);
    for (int i = 0; i < 3; i++) step(mk(0, 5, 0, 0, 1, 5, 1, 1, 0, O_MEM), "memwait", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM), "memack", 1'b1);
    check("memwait_stall_cnt", 64'(stall_cnt), 64'd3);
    check("memwait_flush_cnt", 64'(flush_cnt), 64'd0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM), "after_ack", 1'b1);

    // Timeout: never acked, four stall cycles then release and sticky error
    do_reset(1);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_MEM), "to_wait", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_NORM), "to_release", 1'b1);
    check("timeout_err", 64'(err), 64'd1);
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM), "to_idle", 1'b1);
    check("timeout_err_sticky", 64'(err), 64'd1);
    check("timeout_stall_cnt", 64'(stall_cnt), 64'(MEM_TIMEOUT));
    do_reset(1);
    check("reset_clears_err", 64'(err), 64'd0);
    check("reset_clears_cnt", 64'(stall_cnt), 64'd0);

    // Reset asserted in the middle of a memory wait
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_MEM), "rw_wait", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_MEM), "rw_wait", 1'b1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_RST), "rw_reset", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR), "rw_resume", 1'b1);

    // Counter saturation under a held load-use hazard
    do_reset(1);
    for (int i = 0; i < CNT_MAX + 5; i++) step(mk(0, 3, 0, 0, 1, 3, 0, 0, 0, O_HAZ), "sat", 1'b1);
    check("stall_cnt_saturates", 64'(stall_cnt), 64'(CNT_MAX));

    // Randomized traffic against the model
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      rv = mk(($urandom_range(63) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
              ($urandom_range(3) == 0), 1'($urandom_range(1)), ($urandom_range(3) == 0), 5'd0);
      step(rv, "rand", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
